// File: rtl/pipeline_ctrl_pkg.sv
// Shared control definitions for the pipeline controller: FSM states,
// register-index width, counter widths and the canned control words.
package pipeline_ctrl_pkg;
  localparam int REG_IDX_W       = 4;
  localparam int MEM_TIMEOUT_DEF = 15;
  localparam int WAIT_CNT_W      = 8;
  localparam int STALL_CNT_W     = 16;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } ctrl_state_e;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic mem_wb_en;
    logic if_id_flush;
    logic id_ex_flush;
    logic mem_wb_flush;
  } ctl_t;

  localparam ctl_t CTL_RESET    = ctl_t'(8'b00000_111);
  localparam ctl_t CTL_IDLE     = ctl_t'(8'b00000_000);
  localparam ctl_t CTL_RUN      = ctl_t'(8'b11111_000);
  localparam ctl_t CTL_MEM_STL  = ctl_t'(8'b00000_001);
  localparam ctl_t CTL_BRANCH   = ctl_t'(8'b11111_110);
  // Front end holds; the ID/EX register still loads, taking the bubble.
  localparam ctl_t CTL_LOAD_USE = ctl_t'(8'b00111_010);
endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard inputs and pipeline-register controls between datapath and controller.
interface pipeline_ctrl_if;
  import pipeline_ctrl_pkg::*;

  logic [REG_IDX_W-1:0]   id_rn, id_rm, ex_rd;
  logic                   id_uses_rn, id_uses_rm;
  logic                   ex_mem_read, ex_branch_taken;
  logic                   mem_req, mem_ready;
  logic                   pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic                   if_id_flush, id_ex_flush, mem_wb_flush;
  logic                   mem_timeout;
  logic [STALL_CNT_W-1:0] stall_cycles;

  modport master (
    output id_rn, id_rm, ex_rd, id_uses_rn, id_uses_rm,
           ex_mem_read, ex_branch_taken, mem_req, mem_ready,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, mem_wb_flush, mem_timeout, stall_cycles
  );

  modport slave (
    input  id_rn, id_rm, ex_rd, id_uses_rn, id_uses_rm,
           ex_mem_read, ex_branch_taken, mem_req, mem_ready,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, mem_wb_flush, mem_timeout, stall_cycles
  );
endinterface

// File: rtl/pipeline_hazard_detect.sv
// Load-use hazard: a load in EX writes a register the ID instruction reads.
module pipeline_hazard_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic [REG_IDX_W-1:0] id_rn,
  input  logic [REG_IDX_W-1:0] id_rm,
  input  logic                 id_uses_rn,
  input  logic                 id_uses_rm,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic                 ex_mem_read,
  output logic                 load_use
);
  assign load_use = ex_mem_read &
                    ((id_uses_rn & (id_rn == ex_rd)) |
                     (id_uses_rm & (id_rm == ex_rd)));
endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller: memory-wait FSM with timeout, branch and
// load-use handling, and a saturating stall-cycle counter.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic reset,
  pipeline_ctrl_if.slave pif
);
  localparam logic [WAIT_CNT_W-1:0] TIMEOUT = WAIT_CNT_W'(MEM_TIMEOUT);

  ctrl_state_e            state_q, state_d;
  logic [WAIT_CNT_W-1:0]  wait_q, wait_d;
  logic [STALL_CNT_W-1:0] stall_q;
  logic                   err_q;
  logic                   load_use, mem_stall;
  ctl_t                   ctl, run_ctl;

  pipeline_hazard_detect u_hazard (
    .id_rn       (pif.id_rn),
    .id_rm       (pif.id_rm),
    .id_uses_rn  (pif.id_uses_rn),
    .id_uses_rm  (pif.id_uses_rm),
    .ex_rd       (pif.ex_rd),
    .ex_mem_read (pif.ex_mem_read),
    .load_use    (load_use)
  );

  // In MEM_WAIT the access is still outstanding, so only mem_ready releases it.
  assign mem_stall = (state_q == ST_MEM_WAIT) ? !pif.mem_ready
                                              : (pif.mem_req & !pif.mem_ready);

  always_comb begin
    run_ctl = CTL_RUN;
    if (pif.ex_branch_taken) run_ctl = CTL_BRANCH;
    else if (load_use)       run_ctl = CTL_LOAD_USE;
  end

  always_comb begin
    ctl     = CTL_IDLE;
    state_d = state_q;
    wait_d  = wait_q;
    if (reset) begin
      ctl     = CTL_RESET;
      state_d = ST_RUN;
      wait_d  = '0;
    end else begin
      case (state_q)
        ST_RUN, ST_MEM_WAIT: begin
          if (mem_stall) begin
            ctl = CTL_MEM_STL;
            if (state_q == ST_RUN) begin
              state_d = ST_MEM_WAIT;
              wait_d  = WAIT_CNT_W'(1);
            end else if (wait_q == TIMEOUT) begin
              state_d = ST_ERROR;
            end else begin
              wait_d = wait_q + WAIT_CNT_W'(1);
            end
          end else begin
            ctl     = run_ctl;
            state_d = ST_RUN;
            wait_d  = '0;
          end
        end
        default: ctl = CTL_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      wait_q  <= '0;
      stall_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (!ctl.pc_en && (stall_q != '1)) stall_q <= stall_q + STALL_CNT_W'(1);
      if (state_d == ST_ERROR) err_q <= 1'b1;
    end
  end

  assign pif.pc_en        = ctl.pc_en;
  assign pif.if_id_en     = ctl.if_id_en;
  assign pif.id_ex_en     = ctl.id_ex_en;
  assign pif.ex_mem_en    = ctl.ex_mem_en;
  assign pif.mem_wb_en    = ctl.mem_wb_en;
  assign pif.if_id_flush  = ctl.if_id_flush;
  assign pif.id_ex_flush  = ctl.id_ex_flush;
  assign pif.mem_wb_flush = ctl.mem_wb_flush;
  // Counters read as cleared for the whole reset window, not just after the edge.
  assign pif.mem_timeout  = err_q & !reset;
  assign pif.stall_cycles = reset ? '0 : stall_q;
endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15: maximum wait cycles on a data-memory access before the error state is entered (legal range 1..255).
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 id_rn, id_rm  in  4 each  ID-stage source register indices.
REQ-005 id_uses_rn, id_uses_rm  in  1 each  ID instruction actually reads rn / rm.
REQ-006 ex_rd  in  4  EX-stage destination register index.
REQ-007 ex_mem_read  in  1  EX-stage instruction is a load.
REQ-008 ex_branch_taken  in  1  branch resolved taken in EX this cycle.
REQ-009 mem_req  in  1  MEM-stage instruction accesses data memory.
REQ-010 mem_ready  in  1  data memory completes the access this cycle.
REQ-011 pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  load enables for PC and pipeline registers.
REQ-012 if_id_flush, id_ex_flush, mem_wb_flush  out  1 each  load a bubble (all control signals 0) into that register.
REQ-013 mem_timeout  out  1  sticky error flag.
REQ-014 stall_cycles  out  16  saturating count of cycles with pc_en=0 (excluding reset).

Function
REQ-015 The FSM SHALL have states RUN, MEM_WAIT and ERROR, held in a registered state vector; all outputs except stall_cycles and mem_timeout SHALL be a combinational decode of the state and current inputs.
REQ-016 Load-use hazard = ex_mem_read & ((id_uses_rn & id_rn==ex_rd) | (id_uses_rm & id_rm==ex_rd)).
REQ-017 RUN, no event: all enables 1, all flushes 0.
REQ-018 RUN, mem_req & !mem_ready: all enables 0, mem_wb_flush 1; next state MEM_WAIT; wait counter loads 1.
REQ-019 RUN, mem_req & mem_ready in the same cycle: no stall; the access is treated as a normal RUN cycle.
REQ-020 RUN, ex_branch_taken (no memory stall): all enables 1, if_id_flush 1, id_ex_flush 1; this overrides a simultaneous load-use hazard.
REQ-021 RUN, load-use hazard only: pc_en 0, if_id_en 0, id_ex_flush 1, ex_mem_en 1, mem_wb_en 1; this lasts exactly one cycle and the state stays RUN.
REQ-022 Priority: memory stall > branch flush > load-use hazard.
REQ-023 MEM_WAIT, !mem_ready: all enables 0, mem_wb_flush 1; wait counter +1; when the counter equals MEM_TIMEOUT, next state ERROR.
REQ-024 MEM_WAIT, mem_ready: outputs are evaluated exactly as in RUN for this cycle (branch and load-use rules apply); next state RUN; counter clears.
REQ-025 ERROR: all enables 0, all flushes 0, mem_timeout 1; the state is left only by reset.
REQ-026 stall_cycles SHALL increment on every cycle with pc_en=0 and saturate at 0xFFFF.

Reset
REQ-027 While reset is 1: state RUN, wait counter 0, stall_cycles 0, mem_timeout 0, all enables 0, all flushes 1.
REQ-028 Reset asserted during MEM_WAIT or ERROR SHALL return to RUN on the next edge; the first post-reset cycle SHALL be a plain RUN cycle.

Structure
REQ-029 The state enum, REG_IDX_W=4 and the default MEM_TIMEOUT SHALL live in the shared control package.
REQ-030 The hazard comparison of REQ-016 SHALL be one combinational sub-module, pipeline_hazard_detect; the FSM, counters and output decode stay in pipeline_ctrl.

Verification
REQ-031 ex_mem_read=1, ex_rd=3, id_uses_rn=1, id_rn=3 for 1 cycle -> pc_en=0, if_id_en=0, id_ex_flush=1, mem_wb_en=1; stall_cycles=1.
REQ-032 Load-use condition of REQ-031 with ex_branch_taken=1 -> pc_en=1, if_id_flush=1, id_ex_flush=1; stall_cycles unchanged.
REQ-033 mem_req=1, mem_ready low for 4 cycles then high -> 4 cycles of all enables 0 with mem_wb_flush=1, release on the 5th cycle; stall_cycles=4.
REQ-034 mem_req=1, mem_ready never asserted, MEM_TIMEOUT=15 -> ERROR after 15 wait cycles (16th edge); mem_timeout=1 held, enables 0, until reset clears to RUN.
REQ-035 In MEM_WAIT at the 2nd wait cycle, ex_branch_taken=1, then mem_ready=1 -> branch flush occurs only in the release cycle; no flush in earlier wait cycles.
